// File: rtl/rsa_pkg.sv
// Shared definitions for the modular exponentiator: FSM states, default operand width
// and the multiply period helper.
package rsa_pkg;

    localparam int unsigned DefaultWidth = 128;
    localparam int unsigned N = 2 * DefaultWidth;

    typedef enum logic [2:0] {
        StIdle,
        StReduce,
        StStep,
        StFin,
        StFail
    } state_e;

    // One load cycle plus one cycle per operand bit.
    function automatic int unsigned mul_period(input int unsigned op_width);
        return op_width + 1;
    endfunction

endpackage

// File: rtl/rsa_mod_exp_if.sv
// Request/response bundle of the modular exponentiator: operands and start in,
// result and status out.
interface rsa_mod_exp_if #(
    parameter int unsigned WIDTH = rsa_pkg::DefaultWidth
);
    localparam int unsigned OpW = 2 * WIDTH;

    logic           start;
    logic [OpW-1:0] base;
    logic [OpW-1:0] exponent;
    logic [OpW-1:0] modulus;
    logic [OpW-1:0] result;
    logic           busy;
    logic           done;
    logic           err;

    modport master (
        output start, base, exponent, modulus,
        input  result, busy, done, err
    );

    modport slave (
        input  start, base, exponent, modulus,
        output result, busy, done, err
    );

endinterface

// File: rtl/rsa_mod_mul.sv
// Serial interleaved modular multiplier: acc = a * b mod m, MSB-first over a,
// one operand bit per cycle after a single load cycle. Requires b < m.
module rsa_mod_mul import rsa_pkg::*; #(
    parameter int unsigned OpW = N
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           load,
    input  logic [OpW-1:0] a,
    input  logic [OpW-1:0] b,
    input  logic [OpW-1:0] m,
    output logic [OpW-1:0] acc_out,
    output logic           mul_done
);

    localparam int unsigned CntW = $clog2(mul_period(OpW));
    localparam int unsigned AccW = OpW + 2;

    logic [OpW-1:0]  a_q;
    logic [AccW-1:0] b_q;
    logic [AccW-1:0] m_q;
    logic [AccW-1:0] acc_q;
    logic [AccW-1:0] acc_d;
    logic [AccW-1:0] dbl;
    logic [AccW-1:0] dbl_red;
    logic [AccW-1:0] sum;
    logic [CntW-1:0] cnt_q;
    logic            done_q;

    // Two spare bits keep 2*acc + b representable without wrap.
    always_comb begin
        dbl     = acc_q << 1;
        dbl_red = (dbl >= m_q) ? dbl - m_q : dbl;
        sum     = a_q[OpW-1] ? dbl_red + b_q : dbl_red;
        acc_d   = (sum >= m_q) ? sum - m_q : sum;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (load) begin
            a_q    <= a;
            b_q    <= {2'b00, b};
            m_q    <= {2'b00, m};
            acc_q  <= '0;
            cnt_q  <= CntW'(OpW);
            done_q <= 1'b0;
        end else if (cnt_q != '0) begin
            acc_q  <= acc_d;
            a_q    <= {a_q[OpW-2:0], 1'b0};
            cnt_q  <= cnt_q - CntW'(1);
            done_q <= (cnt_q == CntW'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign acc_out  = acc_q[OpW-1:0];
    assign mul_done = done_q;

endmodule

// File: rtl/rsa_mod_exp.sv
// Right-to-left square-and-multiply exponentiator: result = base^exponent mod modulus,
// with the r-path and b-path multipliers running in parallel for each exponent bit.
module rsa_mod_exp import rsa_pkg::*; #(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input logic         clk,
    input logic         reset_n,
    rsa_mod_exp_if.slave bus
);

    localparam int unsigned OpW = 2 * WIDTH;

    state_e         state_q, state_d;
    logic [OpW-1:0] e_q, e_d;
    logic [OpW-1:0] m_q, m_d;
    logic [OpW-1:0] r_q, r_d;
    logic [OpW-1:0] b_q, b_d;
    logic [OpW-1:0] result_q, result_d;
    logic           err_q, err_d;
    logic           done_q, done_d;

    logic           load;
    logic           advance;
    logic [OpW-1:0] r_cur, b_cur, e_cur;
    logic [OpW-1:0] mul_m, ra, rb, ba, bb;
    logic [OpW-1:0] r_acc, b_acc;
    logic           r_done, b_done, mul_done;

    assign mul_done = r_done & b_done;

    always_comb begin
        state_d  = state_q;
        e_d      = e_q;
        m_d      = m_q;
        r_d      = r_q;
        b_d      = b_q;
        result_d = result_q;
        err_d    = err_q;
        done_d   = 1'b0;
        load     = 1'b0;
        advance  = 1'b0;
        r_cur    = r_q;
        b_cur    = b_q;
        e_cur    = e_q;
        mul_m    = m_q;
        ra       = r_q;
        rb       = b_q;
        ba       = b_q;
        bb       = b_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    e_d     = bus.exponent;
                    m_d     = bus.modulus;
                    err_d   = 1'b0;
                    // Reduction multiply b = base * 1 starts on the accept edge.
                    load    = 1'b1;
                    mul_m   = bus.modulus;
                    ba      = bus.base;
                    bb      = OpW'(1);
                    ra      = '0;
                    rb      = '0;
                    state_d = StReduce;
                end
            end
            StReduce: begin
                if (m_q < OpW'(2)) begin
                    state_d = StFail;
                end else if (mul_done) begin
                    advance = 1'b1;
                    r_cur   = OpW'(1);
                    b_cur   = b_acc;
                    e_cur   = e_q;
                end
            end
            StStep: begin
                if (mul_done) begin
                    advance = 1'b1;
                    r_cur   = e_q[0] ? r_acc : r_q;
                    b_cur   = b_acc;
                    e_cur   = e_q >> 1;
                end
            end
            StFin: begin
                result_d = r_q;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            StFail: begin
                result_d = '0;
                err_d    = 1'b1;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Commit the finished multiply and launch the next one in the same cycle.
        if (advance) begin
            r_d = r_cur;
            b_d = b_cur;
            e_d = e_cur;
            if (e_cur == '0) begin
                state_d = StFin;
            end else begin
                load    = 1'b1;
                ra      = r_cur;
                rb      = b_cur;
                ba      = b_cur;
                bb      = b_cur;
                state_d = StStep;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            e_q      <= '0;
            m_q      <= '0;
            r_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            e_q      <= e_d;
            m_q      <= m_d;
            r_q      <= r_d;
            b_q      <= b_d;
            result_q <= result_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    rsa_mod_mul #(
        .OpW (OpW)
    ) u_mul_r (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .a        (ra),
        .b        (rb),
        .m        (mul_m),
        .acc_out  (r_acc),
        .mul_done (r_done)
    );

    rsa_mod_mul #(
        .OpW (OpW)
    ) u_mul_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .a        (ba),
        .b        (bb),
        .m        (mul_m),
        .acc_out  (b_acc),
        .mul_done (b_done)
    );

    assign bus.result = result_q;
    assign bus.err    = err_q;
    assign bus.done   = done_q;
    assign bus.busy   = (state_q != StIdle);

endmodule

// File: tb/tb_rsa_mod_exp.sv
// Directed bench for rsa_mod_exp at WIDTH=8 with hand-computed results and latencies.
module tb_rsa_mod_exp;

    localparam int unsigned W = 8;

    typedef struct {
        logic [15:0] b;
        logic [15:0] e;
        logic [15:0] m;
        logic [15:0] res;
        logic        er;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    rsa_mod_exp_if #(.WIDTH(W)) bus ();

    rsa_mod_exp #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Accepts one request, scrambles the inputs afterwards, optionally pokes start while busy.
    task automatic run_op(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                          input int poke_at, output logic [15:0] res, output logic er,
                          output logic er_acc, output logic busy_acc, output int lat);
        bit got = 0;
        @(negedge clk);
        bus.base     = b;
        bus.exponent = e;
        bus.modulus  = m;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        er_acc       = bus.err;
        busy_acc     = bus.busy;
        bus.base     = 16'($urandom);
        bus.exponent = 16'($urandom);
        bus.modulus  = 16'($urandom);
        lat = -1;
        for (int i = 1; i <= 400 && !got; i++) begin
            @(posedge clk);
            #1;
            bus.start = (i == poke_at);
            if (bus.done) begin
                got = 1;
                lat = i;
            end
        end
        bus.start = 1'b0;
        res = bus.result;
        er  = bus.err;
    endtask

    initial begin
        logic [15:0] res;
        logic        er, er_acc, busy_acc;
        int          lat;
        int          seen;

        bus.start    = 1'b0;
        bus.base     = '0;
        bus.exponent = '0;
        bus.modulus  = '0;

        vecs.push_back('{16'd7,     16'd13,  16'd143,   16'd46,    1'b0, 86});
        vecs.push_back('{16'd5,     16'd0,   16'd143,   16'd1,     1'b0, 18});
        vecs.push_back('{16'd200,   16'd1,   16'd143,   16'd57,    1'b0, 35});
        vecs.push_back('{16'd7,     16'd13,  16'd1,     16'd0,     1'b1, 2});
        vecs.push_back('{16'd42,    16'd7,   16'd143,   16'd81,    1'b0, 69});
        vecs.push_back('{16'd81,    16'd103, 16'd143,   16'd42,    1'b0, 137});
        vecs.push_back('{16'd9,     16'd5,   16'd0,     16'd0,     1'b1, 2});
        vecs.push_back('{16'd2,     16'd10,  16'd1000,  16'd24,    1'b0, 86});
        vecs.push_back('{16'd65535, 16'd2,   16'd65521, 16'd196,   1'b0, 52});
        vecs.push_back('{16'd12345, 16'd3,   16'd65521, 16'd31927, 1'b0, 52});

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.result", 32'(bus.result), 32'd0);
        check_eq("rst.busy",   32'(bus.busy),   32'd0);
        check_eq("rst.done",   32'(bus.done),   32'd0);
        check_eq("rst.err",    32'(bus.err),    32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[k]) begin
            run_op(vecs[k].b, vecs[k].e, vecs[k].m, 0, res, er, er_acc, busy_acc, lat);
            check_eq($sformatf("v%0d.result", k),   32'(res),      32'(vecs[k].res));
            check_eq($sformatf("v%0d.err", k),      32'(er),       32'(vecs[k].er));
            check_eq($sformatf("v%0d.latency", k),  32'(lat),      32'(vecs[k].lat));
            check_eq($sformatf("v%0d.err_clr", k),  32'(er_acc),   32'd0);
            check_eq($sformatf("v%0d.busy", k),     32'(busy_acc), 32'd1);
            @(posedge clk);
            #1;
            check_eq($sformatf("v%0d.done_pulse", k), 32'(bus.done),   32'd0);
            check_eq($sformatf("v%0d.hold", k),       32'(bus.result), 32'(vecs[k].res));
        end

        // start while busy must not disturb the running operation
        run_op(16'd7, 16'd13, 16'd143, 20, res, er, er_acc, busy_acc, lat);
        check_eq("poke.result",  32'(res), 32'd46);
        check_eq("poke.latency", 32'(lat), 32'd86);
        check_eq("poke.err",     32'(er),  32'd0);

        // reset during the exponent loop
        @(negedge clk);
        bus.base     = 16'd7;
        bus.exponent = 16'd13;
        bus.modulus  = 16'd143;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("abort.result", 32'(bus.result), 32'd0);
        check_eq("abort.busy",   32'(bus.busy),   32'd0);
        check_eq("abort.done",   32'(bus.done),   32'd0);
        check_eq("abort.err",    32'(bus.err),    32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        check_eq("abort.no_done", 32'(seen), 32'd0);
        run_op(16'd5, 16'd0, 16'd143, 0, res, er, er_acc, busy_acc, lat);
        check_eq("after_abort.result",  32'(res), 32'd1);
        check_eq("after_abort.latency", 32'(lat), 32'd18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
